// File: rtl/piano_mode_scheduler_pkg.sv
// Shared constants for the piano mode scheduler: FSM states, mode/active/exit codes.
package piano_mode_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_FREE  = 3'b001;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_STUDY = 3'b100;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_FREE  = 2'b01;
  localparam logic [1:0] ACT_AUTO  = 2'b10;
  localparam logic [1:0] ACT_STUDY = 2'b11;

  localparam logic [1:0] EXIT_NONE   = 2'b00;
  localparam logic [1:0] EXIT_DONE   = 2'b01;
  localparam logic [1:0] EXIT_ABORT  = 2'b10;
  localparam logic [1:0] EXIT_SWITCH = 2'b11;

  localparam logic [6:0] IDLE_LED_DEFAULT = 7'b1111111;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == MODE_FREE) || (v == MODE_AUTO) || (v == MODE_STUDY);
  endfunction

  function automatic logic [1:0] mode_to_active(input logic [2:0] m);
    logic [1:0] a;
    case (m)
      MODE_FREE:  a = ACT_FREE;
      MODE_AUTO:  a = ACT_AUTO;
      MODE_STUDY: a = ACT_STUDY;
      default:    a = ACT_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/piano_mode_scheduler_button_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter, registered rising-edge pulse.
module piano_mode_scheduler_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // The counter only advances while the synchronised input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/piano_mode_scheduler.sv
// Piano mode controller: sequences one engine at a time through select/start/run/drain
// and owns the shared LED bank and note bus on behalf of the granted engine.
module piano_mode_scheduler
  import piano_mode_scheduler_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned DRAIN_CYCLES    = 16,
  parameter logic [6:0]  IDLE_LED        = IDLE_LED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode_sel,
  input  logic       confirm,
  input  logic       abort,
  input  logic [6:0] free_leds,
  input  logic [6:0] auto_leds,
  input  logic [6:0] study_leds,
  input  logic [2:0] free_note,
  input  logic [2:0] auto_note,
  input  logic [2:0] study_note,
  input  logic       auto_done,
  input  logic       study_done,
  output logic [2:0] mode_en,
  output logic       mode_start,
  output logic [6:0] leds,
  output logic [2:0] note,
  output logic [1:0] active_mode,
  output logic [1:0] last_exit,
  output logic       busy
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  logic confirm_p, abort_p;
  logic confirm_level_unused, abort_level_unused;

  piano_mode_scheduler_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (confirm),
    .level_o (confirm_level_unused),
    .rise_o  (confirm_p)
  );

  piano_mode_scheduler_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (abort),
    .level_o (abort_level_unused),
    .rise_o  (abort_p)
  );

  state_e         state_q;
  logic [2:0]     grant_q;
  logic [DCW-1:0] drain_cnt_q;
  logic [2:0]     mode_en_q;
  logic           mode_start_q;
  logic [6:0]     leds_q;
  logic [2:0]     note_q;
  logic [1:0]     active_q;
  logic [1:0]     last_exit_q;
  logic           busy_q;

  logic [6:0] eng_leds;
  logic [2:0] eng_note;
  logic       eng_done;
  logic       run_exit;
  logic [1:0] exit_code;

  // Only the granted engine is visible; free play has no done source.
  always_comb begin
    eng_leds = 7'd0;
    eng_note = 3'd0;
    eng_done = 1'b0;
    case (grant_q)
      MODE_FREE: begin
        eng_leds = free_leds;
        eng_note = free_note;
      end
      MODE_AUTO: begin
        eng_leds = auto_leds;
        eng_note = auto_note;
        eng_done = auto_done;
      end
      MODE_STUDY: begin
        eng_leds = study_leds;
        eng_note = study_note;
        eng_done = study_done;
      end
      default: ;
    endcase
  end

  always_comb begin
    run_exit  = 1'b1;
    exit_code = EXIT_NONE;
    if (eng_done)                  exit_code = EXIT_DONE;
    else if (abort_p)              exit_code = EXIT_ABORT;
    else if (mode_sel != grant_q)  exit_code = EXIT_SWITCH;
    else                           run_exit  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= MODE_NONE;
      drain_cnt_q  <= '0;
      mode_en_q    <= MODE_NONE;
      mode_start_q <= 1'b0;
      leds_q       <= IDLE_LED;
      note_q       <= 3'd0;
      active_q     <= ACT_NONE;
      last_exit_q  <= EXIT_NONE;
      busy_q       <= 1'b0;
    end else begin
      mode_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Switches must be parked at zero first so a stale selection cannot auto-start.
          if (mode_sel == MODE_NONE) begin
            state_q <= ST_SELECT;
            leds_q  <= 7'd0;
            note_q  <= 3'd0;
          end
        end
        ST_SELECT: begin
          if (confirm_p && is_onehot3(mode_sel)) begin
            state_q      <= ST_START;
            grant_q      <= mode_sel;
            mode_en_q    <= mode_sel;
            mode_start_q <= 1'b1;
            active_q     <= mode_to_active(mode_sel);
            last_exit_q  <= EXIT_NONE;
            busy_q       <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_RUN;
          leds_q  <= eng_leds;
          note_q  <= eng_note;
        end
        ST_RUN: begin
          if (run_exit) begin
            state_q     <= ST_DRAIN;
            mode_en_q   <= MODE_NONE;
            leds_q      <= 7'd0;
            note_q      <= 3'd0;
            active_q    <= ACT_NONE;
            last_exit_q <= exit_code;
            drain_cnt_q <= '0;
          end else begin
            leds_q <= eng_leds;
            note_q <= eng_note;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= ST_IDLE;
            grant_q <= MODE_NONE;
            busy_q  <= 1'b0;
            leds_q  <= IDLE_LED;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          grant_q   <= MODE_NONE;
          mode_en_q <= MODE_NONE;
          leds_q    <= IDLE_LED;
          note_q    <= 3'd0;
          active_q  <= ACT_NONE;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mode_en     = mode_en_q;
  assign mode_start  = mode_start_q;
  assign leds        = leds_q;
  assign note        = note_q;
  assign active_mode = active_q;
  assign last_exit   = last_exit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piano_mode_scheduler.sv
// Self-checking bench for piano_mode_scheduler with a scoreboard on the arbitrated LED/note path.
module tb_piano_mode_scheduler;

  localparam int         DEB      = 4;
  localparam int         DRAIN    = 16;
  localparam logic [6:0] IDLE_PAT = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode_sel = 3'b000;
  logic       confirm = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] free_leds = '0, auto_leds = '0, study_leds = '0;
  logic [2:0] free_note = '0, auto_note = '0, study_note = '0;
  logic       auto_done = 1'b0, study_done = 1'b0;

  logic [2:0] mode_en;
  logic       mode_start;
  logic [6:0] leds;
  logic [2:0] note;
  logic [1:0] active_mode;
  logic [1:0] last_exit;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  piano_mode_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .DRAIN_CYCLES   (DRAIN),
    .IDLE_LED       (IDLE_PAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_sel   (mode_sel),
    .confirm    (confirm),
    .abort      (abort),
    .free_leds  (free_leds),
    .auto_leds  (auto_leds),
    .study_leds (study_leds),
    .free_note  (free_note),
    .auto_note  (auto_note),
    .study_note (study_note),
    .auto_done  (auto_done),
    .study_done (study_done),
    .mode_en    (mode_en),
    .mode_start (mode_start),
    .leds       (leds),
    .note       (note),
    .active_mode(active_mode),
    .last_exit  (last_exit),
    .busy       (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds confirm for 'hold' cycles inside a 'budget'-cycle window, counting start pulses.
  task automatic press_confirm(input int hold, input int budget, output int starts,
                               output logic [2:0] en_seen);
    starts  = 0;
    en_seen = 3'b000;
    for (int c = 0; c < budget; c++) begin
      confirm = (c < hold);
      tick();
      if (mode_start === 1'b1) begin
        starts++;
        en_seen = mode_en;
      end
    end
    confirm = 1'b0;
  endtask

  // Ticks until busy falls; returns the number of extra busy samples seen.
  task automatic wait_idle(output int cycles, output bit en_leak);
    cycles  = 0;
    en_leak = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (busy !== 1'b1) break;
      cycles++;
      if (mode_en !== 3'b000) en_leak = 1'b1;
    end
  endtask

  task automatic test_reset();
    mode_sel = 3'b010;
    rst_n    = 1'b0;
    repeat (2) tick();
    checks++; if (leds !== IDLE_PAT) begin errors++; $display("FAIL reset_leds: got %b want %b", leds, IDLE_PAT); end
    checks++; if (mode_en !== 3'b000) begin errors++; $display("FAIL reset_mode_en: got %b want 000", mode_en); end
    checks++; if (mode_start !== 1'b0) begin errors++; $display("FAIL reset_mode_start: got %b want 0", mode_start); end
    checks++; if ({note, active_mode, last_exit, busy} !== 8'd0) begin errors++;
      $display("FAIL reset_misc: note=%0d active=%b exit=%b busy=%b want all 0", note, active_mode, last_exit, busy); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (leds !== IDLE_PAT) begin errors++; $display("FAIL idle_hold_stale_sel: leds=%b want %b", leds, IDLE_PAT); end
    mode_sel = 3'b000;
    tick();
    checks++; if (leds !== 7'd0) begin errors++; $display("FAIL enter_select: leds=%b want 0000000", leds); end
    $display("test_reset: done");
  endtask

  task automatic test_study_run();
    int starts, cyc;
    logic [2:0] en_seen;
    logic [9:0] exp_v;
    bit leak;
    mode_sel = 3'b100;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 1 || en_seen !== 3'b100) begin errors++;
      $display("FAIL study_start: pulses=%0d en=%b want 1 pulse en=100", starts, en_seen); end
    checks++; if (active_mode !== 2'b11 || mode_en !== 3'b100 || busy !== 1'b1 || mode_start !== 1'b0) begin errors++;
      $display("FAIL study_run_state: active=%b en=%b busy=%b start=%b want 11/100/1/0", active_mode, mode_en, busy, mode_start); end
    for (int i = 0; i < 8; i++) begin
      study_leds = (i == 0) ? 7'b0000100 : 7'($urandom);
      study_note = (i == 0) ? 3'd3 : 3'($urandom);
      free_leds  = 7'($urandom);
      free_note  = 3'($urandom);
      auto_leds  = 7'($urandom);
      auto_note  = 3'($urandom);
      sb_q.push_back({study_leds, study_note});
      tick();
      exp_v = sb_q.pop_front();
      checks++; if ({leds, note} !== exp_v) begin errors++;
        $display("FAIL study_data[%0d]: leds=%b note=%0d want leds=%b note=%0d", i, leds, note, exp_v[9:3], exp_v[2:0]); end
      $display("study txn %0d: leds=%b note=%0d", i, leds, note);
    end
    study_done = 1'b1;
    tick();
    study_done = 1'b0;
    checks++; if (last_exit !== 2'b01 || mode_en !== 3'b000 || leds !== 7'd0 || busy !== 1'b1 || active_mode !== 2'b00) begin errors++;
      $display("FAIL study_done_exit: exit=%b en=%b leds=%b busy=%b act=%b want 01/000/0/1/00", last_exit, mode_en, leds, busy, active_mode); end
    wait_idle(cyc, leak);
    checks++; if (cyc + 1 != DRAIN || leak) begin errors++;
      $display("FAIL study_drain_len: got %0d cycles leak=%0d want %0d leak=0", cyc + 1, leak, DRAIN); end
    checks++; if (leds !== IDLE_PAT || last_exit !== 2'b01) begin errors++;
      $display("FAIL study_back_idle: leds=%b exit=%b want %b/01", leds, last_exit, IDLE_PAT); end
    mode_sel = 3'b000;
    tick();
    $display("test_study_run: done");
  endtask

  task automatic test_done_abort_priority();
    int starts, cyc;
    logic [2:0] en_seen;
    bit leak;
    mode_sel = 3'b010;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 1 || en_seen !== 3'b010 || active_mode !== 2'b10) begin errors++;
      $display("FAIL auto_start: pulses=%0d en=%b act=%b want 1/010/10", starts, en_seen, active_mode); end
    study_done = 1'b1;
    tick();
    study_done = 1'b0;
    tick();
    checks++; if (mode_en !== 3'b010 || busy !== 1'b1 || last_exit !== 2'b00) begin errors++;
      $display("FAIL auto_ignore_study_done: en=%b busy=%b exit=%b want 010/1/00", mode_en, busy, last_exit); end
    auto_done = 1'b1;
    abort     = 1'b1;
    tick();
    auto_done = 1'b0;
    checks++; if (last_exit !== 2'b01 || mode_en !== 3'b000) begin errors++;
      $display("FAIL done_over_abort: exit=%b en=%b want 01/000", last_exit, mode_en); end
    cyc = 1;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (busy === 1'b1) cyc++;
    end
    abort = 1'b0;
    begin
      int more;
      wait_idle(more, leak);
      cyc += more;
    end
    checks++; if (cyc != DRAIN || last_exit !== 2'b01) begin errors++;
      $display("FAIL auto_drain: cycles=%0d exit=%b want %0d/01", cyc, last_exit, DRAIN); end
    mode_sel = 3'b000;
    tick();
    mode_sel = 3'b010;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 1) begin errors++; $display("FAIL auto_restart: pulses=%0d want 1", starts); end
    for (int c = 0; c < 12; c++) begin
      abort = (c < 10);
      tick();
    end
    abort = 1'b0;
    checks++; if (last_exit !== 2'b10 || mode_en !== 3'b000 || busy !== 1'b1) begin errors++;
      $display("FAIL abort_exit: exit=%b en=%b busy=%b want 10/000/1", last_exit, mode_en, busy); end
    wait_idle(cyc, leak);
    mode_sel = 3'b000;
    tick();
    $display("test_done_abort_priority: done");
  endtask

  task automatic test_invalid_select();
    int starts;
    logic [2:0] en_seen;
    mode_sel = 3'b011;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 0 || busy !== 1'b0 || leds !== 7'd0) begin errors++;
      $display("FAIL multi_hot_ignored: pulses=%0d busy=%b leds=%b want 0/0/0", starts, busy, leds); end
    mode_sel = 3'b001;
    press_confirm(2, 22, starts, en_seen);
    checks++; if (starts != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL glitch_ignored: pulses=%0d busy=%b want 0/0", starts, busy); end
    mode_sel = 3'b000;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL zero_sel_ignored: pulses=%0d busy=%b want 0/0", starts, busy); end
    $display("test_invalid_select: done");
  endtask

  task automatic test_switch_change();
    int starts, cyc;
    logic [2:0] en_seen;
    logic [9:0] exp_v;
    bit leak;
    mode_sel = 3'b001;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 1 || en_seen !== 3'b001 || active_mode !== 2'b01) begin errors++;
      $display("FAIL free_start: pulses=%0d en=%b act=%b want 1/001/01", starts, en_seen, active_mode); end
    for (int i = 0; i < 6; i++) begin
      free_leds  = 7'($urandom);
      free_note  = 3'($urandom);
      study_leds = 7'($urandom);
      study_note = 3'($urandom);
      study_done = (i == 2);
      auto_done  = (i == 4);
      sb_q.push_back({free_leds, free_note});
      tick();
      study_done = 1'b0;
      auto_done  = 1'b0;
      exp_v = sb_q.pop_front();
      checks++; if ({leds, note} !== exp_v || mode_en !== 3'b001) begin errors++;
        $display("FAIL free_data[%0d]: leds=%b note=%0d en=%b want leds=%b note=%0d en=001", i, leds, note, mode_en, exp_v[9:3], exp_v[2:0]); end
      $display("free txn %0d: leds=%b note=%0d", i, leds, note);
    end
    mode_sel = 3'b011;
    tick();
    checks++; if (last_exit !== 2'b11 || mode_en !== 3'b000 || active_mode !== 2'b00) begin errors++;
      $display("FAIL switch_exit: exit=%b en=%b act=%b want 11/000/00", last_exit, mode_en, active_mode); end
    wait_idle(cyc, leak);
    checks++; if (cyc + 1 != DRAIN || leak || leds !== IDLE_PAT) begin errors++;
      $display("FAIL switch_drain: cycles=%0d leak=%0d leds=%b want %0d/0/%b", cyc + 1, leak, leds, DRAIN, IDLE_PAT); end
    mode_sel = 3'b000;
    tick();
    $display("test_switch_change: done");
  endtask

  task automatic test_async_reset();
    int starts;
    logic [2:0] en_seen;
    mode_sel = 3'b001;
    press_confirm(10, 22, starts, en_seen);
    checks++; if (starts != 1 || mode_en !== 3'b001) begin errors++;
      $display("FAIL arst_setup: pulses=%0d en=%b want 1/001", starts, mode_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mode_en !== 3'b000 || leds !== IDLE_PAT || busy !== 1'b0 || active_mode !== 2'b00) begin errors++;
      $display("FAIL async_reset: en=%b leds=%b busy=%b act=%b want 000/%b/0/00", mode_en, leds, busy, active_mode, IDLE_PAT); end
    tick();
    rst_n = 1'b1;
    mode_sel = 3'b000;
    tick();
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_study_run();
    test_done_abort_priority();
    test_invalid_select();
    test_switch_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
